// File: rtl/key_debounce_100hz_pkg.sv
// key_pkg: shared FSM state type and default timing constants for the button blocks.
package key_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t;

    localparam int KEY_DEB_TICKS_DEF  = 2;
    localparam int KEY_LONG_TICKS_DEF = 100;

    function automatic int key_cnt_width(input int deb, input int lng);
        return $clog2(((deb > lng) ? deb : lng) + 1);
    endfunction

endpackage

// File: rtl/key_debounce_100hz_if.sv
// key_debounce_100hz_if: button pin in, debounced level (and key_long with KEY_LONG_PRESS_EN) out.
interface key_debounce_100hz_if;
    logic key_raw;
    logic key_stable;
`ifdef KEY_LONG_PRESS_EN
    logic key_long;
    modport master (output key_raw, input key_stable, input key_long);
    modport slave (input key_raw, output key_stable, output key_long);
`else
    modport master (output key_raw, input key_stable);
    modport slave (input key_raw, output key_stable);
`endif
endinterface

// File: rtl/key_debounce_100hz_sync.sv
// key_sync_2ff: normalises pin polarity to pressed=1 and synchronises it through two flops.
module key_sync_2ff #(
    parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
    input  logic clk_100Hz,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_s
);
    logic meta;

    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            key_s <= 1'b0;
        end else begin
            meta  <= KEY_ACTIVE_HIGH ? key_raw : ~key_raw;
            key_s <= meta;
        end
    end
endmodule

// File: rtl/key_debounce_100hz.sv
// key_debounce_100hz: debounces one push-button on the 100 Hz tick clock.
// Define KEY_LONG_PRESS_EN to add the one-cycle key_long pulse after LONG_TICKS of holding.
module key_debounce_100hz
    import key_pkg::*;
#(
    parameter int DEB_TICKS       = KEY_DEB_TICKS_DEF,
    parameter bit KEY_ACTIVE_HIGH = 1'b1,
    parameter int LONG_TICKS      = KEY_LONG_TICKS_DEF
) (
    input logic                 clk_100Hz,
    input logic                 rst_n,
    key_debounce_100hz_if.slave bus
);
`ifdef KEY_LONG_PRESS_EN
    localparam int CW = key_cnt_width(DEB_TICKS, LONG_TICKS);
`else
    localparam int CW = key_cnt_width(DEB_TICKS, 1);
`endif
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);

    logic            key_s;
    key_state_t      state;
    logic [CW-1:0]   cnt;
    logic            stable_q;

    key_sync_2ff #(.KEY_ACTIVE_HIGH(KEY_ACTIVE_HIGH)) u_sync (
        .clk_100Hz (clk_100Hz),
        .rst_n     (rst_n),
        .key_raw   (bus.key_raw),
        .key_s     (key_s)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // With DEB_TICKS=1 the first agreeing sample qualifies, so the wait states are skipped.
    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            stable_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_s) begin
                        if (DEB_TICKS == 1) begin
                            state    <= PRESSED;
                            cnt      <= '0;
                            stable_q <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state    <= PRESSED;
                        cnt      <= '0;
                        stable_q <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                PRESSED: begin
                    if (!key_s) begin
                        if (DEB_TICKS == 1) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            stable_q <= 1'b0;
                        end else begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (key_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        stable_q <= 1'b0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_stable = stable_q;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_TICKS);

    logic [CW-1:0] hold_cnt;
    logic          long_q;

    // hold_cnt saturates at LONG_TICKS, so a release bounce back into PRESSED cannot re-fire.
    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= (state == PRESSED) && (hold_cnt == LONG_LAST);
            if (state == IDLE)
                hold_cnt <= '0;
            else if (state == PRESSED && hold_cnt != LONG_MAX)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.key_long = long_q;
`endif
endmodule
